// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer arbiter: default geometry and the
// clear-engine state encoding.
package fb_pkg;

   localparam int ADDR_W_DEF   = 13;
   localparam int DATA_W_DEF   = 8;
   localparam int FB_WORDS_DEF = 4800;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } fb_state_e;

endpackage

// File: rtl/fb_arbiter_if.sv
// Bus bundle between the framebuffer arbiter (slave side), its clients and the
// single-port RAM (master side).
interface fb_arbiter_if #(
   parameter int ADDR_W = fb_pkg::ADDR_W_DEF,
   parameter int DATA_W = fb_pkg::DATA_W_DEF
);
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   logic              clear_start;
   logic              clear_busy;

   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, clear_start, ram_rdata,
      output disp_data, disp_valid, wr_ready, clear_busy,
             ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output disp_req, disp_addr, wr_valid, wr_addr, wr_data, clear_start, ram_rdata,
      input  disp_data, disp_valid, wr_ready, clear_busy,
             ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/fb_wr_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued {addr, data} writes.
// Push while full and pop while empty are ignored.
module fb_wr_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push, do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: display reads > clear engine > queued writes.
// Clear engine is built only when FB_ARBITER_CLEAR_EN is defined.
module fb_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int FB_WORDS    = FB_WORDS_DEF,
   parameter int FIFO_DEPTH  = 4,
   parameter int CLEAR_VALUE = 0
) (
   input  logic         clk,
   input  logic         rst,
   fb_arbiter_if.slave  ifc
);
   localparam int                 ENTRY_W    = ADDR_W + DATA_W;
   localparam logic [ADDR_W:0]    ADDR_LIMIT = (ADDR_W+1)'(FB_WORDS);
   localparam logic [DATA_W-1:0]  CLR_WORD   = DATA_W'(CLEAR_VALUE);

   logic               fifo_full, fifo_empty, push, pop;
   logic [ENTRY_W-1:0] fifo_head;
   logic [ADDR_W-1:0]  head_addr;
   logic [DATA_W-1:0]  head_data;
   logic               head_in_range;
   logic               rdy_q;
   logic               clr_active, clr_we;
   logic [ADDR_W-1:0]  clr_addr;
   logic               vld_p0, vld_p1;
   logic [DATA_W-1:0]  disp_data_p1;
   logic               ram_en, ram_we;
   logic [ADDR_W-1:0]  ram_addr;
   logic [DATA_W-1:0]  ram_wdata;

   // Ready is held low until the first clock after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rdy_q <= 1'b0;
      else      rdy_q <= 1'b1;
   end

   assign ifc.wr_ready = rdy_q && !fifo_full;
   assign push         = ifc.wr_valid && ifc.wr_ready;
   assign pop          = !fifo_empty && !clr_active && !ifc.disp_req;
   assign {head_addr, head_data} = fifo_head;
   assign head_in_range = ({1'b0, head_addr} < ADDR_LIMIT);

   fb_wr_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({ifc.wr_addr, ifc.wr_data}),
      .pop   (pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef FB_ARBITER_CLEAR_EN
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

   fb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // The counter only advances in cycles the display leaves free.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      clr_we    = 1'b0;
      case (state_q)
         IDLE: begin
            if (ifc.clear_start) state_d = CLEAR;
         end
         CLEAR: begin
            if (!ifc.disp_req) begin
               clr_we = 1'b1;
               if (clr_cnt_q == LAST_ADDR) begin
                  state_d   = IDLE;
                  clr_cnt_d = '0;
               end else begin
                  clr_cnt_d = clr_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign clr_active     = (state_q == CLEAR);
   assign clr_addr       = clr_cnt_q;
   assign ifc.clear_busy = clr_active;
`else
   logic clear_unused;

   assign clear_unused   = ifc.clear_start ^ (|CLR_WORD);
   assign clr_active     = 1'b0;
   assign clr_we         = 1'b0;
   assign clr_addr       = '0;
   assign ifc.clear_busy = 1'b0;
`endif

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (ifc.disp_req) begin
         ram_en   = 1'b1;
         ram_addr = ifc.disp_addr;
      end else if (clr_we) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = clr_addr;
         ram_wdata = CLR_WORD;
      end else if (pop && head_in_range) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = head_addr;
         ram_wdata = head_data;
      end
   end

   assign ifc.ram_en    = ram_en;
   assign ifc.ram_we    = ram_we;
   assign ifc.ram_addr  = ram_addr;
   assign ifc.ram_wdata = ram_wdata;

   // p0: read issued last cycle, RAM data present now
   // p1: read data registered toward the display
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p0       <= 1'b0;
         vld_p1       <= 1'b0;
         disp_data_p1 <= '0;
      end else begin
         vld_p0 <= ifc.disp_req;
         vld_p1 <= vld_p0;
         if (vld_p0) disp_data_p1 <= ifc.ram_rdata;
      end
   end

   assign ifc.disp_valid = vld_p1;
   assign ifc.disp_data  = disp_data_p1;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural single-port RAM and a
// log of every RAM write (address, data, clock edge).
module tb_fb_arbiter;
   localparam int AW  = 5;
   localparam int DW  = 8;
   localparam int FBW = 16;
   localparam int CLV = 8'hC3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   fb_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .FB_WORDS    (FBW),
      .FIFO_DEPTH  (4),
      .CLEAR_VALUE (CLV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ifc (bus)
   );

   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] wl_addr [$];
   logic [DW-1:0] wl_data [$];
   int            wl_cyc  [$];
   int            cyc = 0;

   initial begin
      for (int i = 0; i < 2**AW; i++) mem[i] = '0;
      bus.ram_rdata = '0;
   end

   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
            wl_addr.push_back(bus.ram_addr);
            wl_data.push_back(bus.ram_wdata);
            wl_cyc.push_back(cyc);
         end else begin
            bus.ram_rdata <= mem[bus.ram_addr];
         end
      end
      cyc <= cyc + 1;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wl_addr.delete();
      wl_data.delete();
      wl_cyc.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   int first_cyc;
   int busy;

   initial begin
      bus.disp_req    = 1'b0;
      bus.disp_addr   = '0;
      bus.wr_valid    = 1'b0;
      bus.wr_addr     = '0;
      bus.wr_data     = '0;
      bus.clear_start = 1'b0;

      // Reset values
      tick();
      tick();
      check_eq("rst_disp_valid", 32'(bus.disp_valid), 0);
      check_eq("rst_disp_data",  32'(bus.disp_data), 0);
      check_eq("rst_clear_busy", 32'(bus.clear_busy), 0);
      check_eq("rst_wr_ready",   32'(bus.wr_ready), 0);
      check_eq("rst_ram_en",     32'(bus.ram_en), 0);
      rst = 1'b1;
      tick();
      check_eq("post_rst_wr_ready", 32'(bus.wr_ready), 1);

      // Display read: 2-cycle latency
      mem[16] = 8'h5A;
      bus.disp_req  = 1'b1;
      bus.disp_addr = 5'h10;
      #1;
      check_eq("rd_ram_en",   32'(bus.ram_en), 1);
      check_eq("rd_ram_we",   32'(bus.ram_we), 0);
      check_eq("rd_ram_addr", 32'(bus.ram_addr), 32'h10);
      tick();
      bus.disp_req = 1'b0;
      check_eq("rd_valid_c1", 32'(bus.disp_valid), 0);
      tick();
      check_eq("rd_valid_c2", 32'(bus.disp_valid), 1);
      check_eq("rd_data_c2",  32'(bus.disp_data), 32'h5A);
      tick();
      check_eq("rd_valid_c3", 32'(bus.disp_valid), 0);
      check_eq("rd_data_hold", 32'(bus.disp_data), 32'h5A);

      // Back-to-back writes, plus one out-of-range address that must be dropped
      clear_log();
      first_cyc = 0;
      for (int i = 0; i < 4; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_addr  = AW'(i + 1);
         bus.wr_data  = DW'((i + 1) * 8'h11);
         check_eq("b2b_wr_ready", 32'(bus.wr_ready), 1);
         tick();
         if (i == 0) first_cyc = cyc;
      end
      bus.wr_addr = 5'd20;
      bus.wr_data = 8'hEE;
      tick();
      bus.wr_valid = 1'b0;
      tick();
      tick();
      tick();
      check_eq("b2b_nwrites", 32'(wl_addr.size()), 4);
      for (int i = 0; i < 4 && i < wl_addr.size(); i++) begin
         check_eq("b2b_addr", 32'(wl_addr[i]), 32'(i + 1));
         check_eq("b2b_data", 32'(wl_data[i]), 32'((i + 1) * 8'h11));
         check_eq("b2b_cycle", 32'(wl_cyc[i]), 32'(first_cyc + i));
      end
      check_eq("oob_dropped", 32'(mem[20]), 0);
      check_eq("b2b_ready_end", 32'(bus.wr_ready), 1);

      // Display hogs the RAM: FIFO fills, then drains when display stops
      clear_log();
      bus.disp_req  = 1'b1;
      bus.disp_addr = '0;
      for (int i = 0; i < 5; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_addr  = AW'(5 + i);
         bus.wr_data  = DW'(8'hA0 + i);
         check_eq("hog_wr_ready", 32'(bus.wr_ready), (i < 4) ? 1 : 0);
         tick();
      end
      bus.wr_valid = 1'b0;
      check_eq("hog_full_ready", 32'(bus.wr_ready), 0);
      check_eq("hog_no_writes", 32'(wl_addr.size()), 0);
      bus.disp_req = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check_eq("drain_nwrites", 32'(wl_addr.size()), 4);
      check_eq("drain_ready", 32'(bus.wr_ready), 1);
      for (int i = 0; i < 4 && i < wl_addr.size(); i++) begin
         check_eq("drain_addr", 32'(wl_addr[i]), 32'(5 + i));
         check_eq("drain_data", 32'(wl_data[i]), 32'(8'hA0 + i));
      end
      tick();
      check_eq("drain_no_fifth", 32'(wl_addr.size()), 4);

`ifdef FB_ARBITER_CLEAR_EN
      // Full clear with a queued write, an ignored restart and one preemption
      clear_log();
      bus.clear_start = 1'b1;
      tick();
      bus.clear_start = 1'b0;
      busy = 0;
      for (int i = 0; i < 40; i++) begin
         if (!bus.clear_busy) break;
         busy++;
         bus.wr_valid    = (busy == 5);
         bus.wr_addr     = 5'd3;
         bus.wr_data     = 8'h77;
         bus.clear_start = (busy == 8);
         bus.disp_req    = (busy == 10);
         bus.disp_addr   = '0;
         tick();
      end
      bus.wr_valid    = 1'b0;
      bus.clear_start = 1'b0;
      bus.disp_req    = 1'b0;
      check_eq("clr_busy_cycles", 32'(busy), 17);
      tick();
      tick();
      check_eq("clr_nwrites", 32'(wl_addr.size()), 17);
      if (wl_addr.size() > 0) check_eq("clr_last_addr", 32'(wl_addr[wl_addr.size()-1]), 3);
      check_eq("clr_mem0",  32'(mem[0]), CLV);
      check_eq("clr_mem1",  32'(mem[1]), CLV);
      check_eq("clr_mem15", 32'(mem[15]), CLV);
      check_eq("clr_mem3",  32'(mem[3]), 32'h77);
      check_eq("clr_idle",  32'(bus.clear_busy), 0);

      // Reset mid-clear at counter 7 with two queued writes
      bus.clear_start = 1'b1;
      tick();
      bus.clear_start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bus.wr_valid = (i == 2 || i == 3);
         bus.wr_addr  = AW'(9 + i);
         bus.wr_data  = 8'h99;
         tick();
      end
      bus.wr_valid = 1'b0;
      check_eq("mid_busy", 32'(bus.clear_busy), 1);
      rst = 1'b0;
      #1;
      check_eq("mid_rst_busy",   32'(bus.clear_busy), 0);
      check_eq("mid_rst_ready",  32'(bus.wr_ready), 0);
      check_eq("mid_rst_valid",  32'(bus.disp_valid), 0);
      check_eq("mid_rst_data",   32'(bus.disp_data), 0);
      check_eq("mid_rst_ram_en", 32'(bus.ram_en), 0);
      tick();
      tick();
      clear_log();
      rst = 1'b1;
      #1;
      check_eq("rel_ram_we", 32'(bus.ram_we), 0);
      tick();
      tick();
      tick();
      check_eq("rel_nwrites", 32'(wl_addr.size()), 0);
      check_eq("rel_busy",    32'(bus.clear_busy), 0);
      check_eq("rel_ready",   32'(bus.wr_ready), 1);
`else
      // Clear engine absent: clear_start has no effect
      clear_log();
      bus.clear_start = 1'b1;
      tick();
      bus.clear_start = 1'b0;
      busy = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.clear_busy) busy++;
         tick();
      end
      check_eq("noclr_busy", 32'(busy), 0);
      check_eq("noclr_nwrites", 32'(wl_addr.size()), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
